mem_stage: RTL

Pipeline MEM stage, directly downstream of the EXE stage. It accepts one instruction per handshake from EXE and waits for the data-SRAM response belonging to any load or store that EXE issued. It extracts and extends load data and forwards the result bus to WB. It also drops responses belonging to requests that were killed by a WB-stage flush, and exports exception, forwarding and hazard status to EXE and ID.

---
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// EXE->MEM->WB pipeline handshake, data-SRAM response and status signals for mem_stage.
// The slave modport is the MEM stage's view; master is the surrounding pipeline.
interface mem_stage_if;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [224:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [216:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_ex;
    logic         wb_ertn;
    logic         wb_refetch;
    logic         out_ms_valid;
    logic         mem_ex;
    logic         mem_ertn;
    logic         mem_refetch;
    logic         mem_write_asid_ehi;
    logic [38:0]  ms_fwd_bus;

    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
               wb_ex, wb_ertn, wb_refetch,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, out_ms_valid, mem_ex, mem_ertn,
               mem_refetch, mem_write_asid_ehi, ms_fwd_bus
    );

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata,
               wb_ex, wb_ertn, wb_refetch,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, out_ms_valid, mem_ex, mem_ertn,
               mem_refetch, mem_write_asid_ehi, ms_fwd_bus
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: waits for the data-SRAM response, extracts load data, forwards to WB,
// and drops responses owed to requests killed by a WB flush.
module mem_stage (
    input logic        clk,
    input logic        reset,
    mem_stage_if.slave pif
);
    logic         ms_valid;
    logic         wait_r;
    logic         rdata_vld;
    logic [31:0]  rdata_r;
    logic [1:0]   discard_cnt;
    // Incoming bus minus mem_re/mem_we, which only matter at acceptance.
    logic [222:0] bus_r;

    logic         refetch;
    logic [9:0]   tlb_bus;
    logic         rdcntid;
    logic [31:0]  vaddr;
    logic         has_int;
    logic [3:0]   exc_op;
    logic [31:0]  rj;
    logic [31:0]  rkd;
    logic [33:0]  csr_data;
    logic [4:0]   ld_op;
    logic         res_from_mem;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  result;
    logic [31:0]  pc;

    assign {refetch, tlb_bus, rdcntid, vaddr, has_int, exc_op, rj, rkd, csr_data, ld_op,
            res_from_mem, gr_we, dest, result, pc} = bus_r;

    logic        flush;
    logic        in_mem_op;
    logic        discard_pend;
    logic        useful_data_ok;
    logic        ms_ready_go;
    logic        ms_allowin;
    logic        accept;
    logic [2:0]  disc_sum;
    logic [1:0]  discard_d;
    logic [31:0] raw;
    logic [31:0] lane;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        csr_rd;
    logic        csr_wr;
    logic        csr_xchg;
    logic        fwd_we;
    logic        fwd_block;

    always_comb begin
        flush          = pif.wb_ex | pif.wb_ertn | pif.wb_refetch;
        in_mem_op      = pif.es_to_ms_bus[213] | pif.es_to_ms_bus[212];
        discard_pend   = discard_cnt != 2'd0;
        useful_data_ok = pif.data_sram_data_ok & ~discard_pend;
        ms_ready_go    = ~wait_r | useful_data_ok | rdata_vld;
        ms_allowin     = ~ms_valid | (ms_ready_go & pif.ws_allowin);
        accept         = pif.es_to_ms_valid & ms_allowin;

        // A response arriving in a flush cycle is retired before the killed ones are added.
        disc_sum = {1'b0, discard_cnt} - {2'b00, pif.data_sram_data_ok & discard_pend};
        if (flush) begin
            disc_sum = disc_sum + {2'b00, ms_valid & wait_r & ~useful_data_ok}
                                + {2'b00, accept & in_mem_op};
        end
        discard_d = (disc_sum > 3'd3) ? 2'd3 : disc_sum[1:0];

        raw  = rdata_vld ? rdata_r : pif.data_sram_rdata;
        lane = raw >> {vaddr[1:0], 3'b000};
        if (ld_op[4]) begin
            load_data = {{24{lane[7]}}, lane[7:0]};
        end else if (ld_op[3]) begin
            load_data = {24'h0, lane[7:0]};
        end else if (ld_op[2]) begin
            load_data = {{16{lane[15]}}, lane[15:0]};
        end else if (ld_op[1]) begin
            load_data = {16'h0, lane[15:0]};
        end else begin
            load_data = raw;
        end
        final_result = res_from_mem ? load_data : result;

        csr_rd    = csr_data[33];
        csr_wr    = csr_data[32];
        csr_xchg  = csr_data[31];
        fwd_we    = ms_valid & gr_we;
        fwd_block = fwd_we & ((res_from_mem & ~ms_ready_go) | csr_rd | csr_wr | csr_xchg
                              | rdcntid);
    end

    assign pif.ms_allowin     = ms_allowin;
    assign pif.ms_to_ws_valid = ms_valid & ms_ready_go;
    assign pif.ms_to_ws_bus   = {refetch, tlb_bus, rdcntid, vaddr, has_int, exc_op, rj, rkd,
                                 csr_data, gr_we, dest, final_result, pc};
    assign pif.out_ms_valid   = ms_valid;
    assign pif.mem_ex         = ms_valid & (has_int | (|exc_op));
    assign pif.mem_ertn       = ms_valid & csr_data[30];
    assign pif.mem_refetch    = ms_valid & refetch;
    assign pif.mem_write_asid_ehi = ms_valid & (((csr_wr | csr_xchg) &
                                    (csr_data[28:15] == 14'h18 || csr_data[28:15] == 14'h11))
                                    | tlb_bus[6]);
    assign pif.ms_fwd_bus     = {fwd_we, dest, final_result, fwd_block};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            wait_r      <= 1'b0;
            rdata_vld   <= 1'b0;
            rdata_r     <= 32'h0;
            discard_cnt <= 2'd0;
            bus_r       <= '0;
        end else begin
            discard_cnt <= discard_d;

            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= pif.es_to_ms_valid;
            end

            if (accept && !flush) begin
                bus_r <= {pif.es_to_ms_bus[224:214], pif.es_to_ms_bus[211:0]};
            end

            if (flush) begin
                wait_r <= 1'b0;
            end else if (accept) begin
                wait_r <= in_mem_op;
            end else if (useful_data_ok) begin
                wait_r <= 1'b0;
            end

            // A held response belongs to the current instruction only, so a flush drops it.
            if (flush) begin
                rdata_vld <= 1'b0;
            end else if (ms_valid && ms_ready_go && pif.ws_allowin) begin
                rdata_vld <= 1'b0;
            end else if (useful_data_ok && ms_valid && wait_r && !pif.ws_allowin) begin
                rdata_vld <= 1'b1;
                rdata_r   <= pif.data_sram_rdata;
            end
        end
    end
endmodule
